// File: rtl/playfield_scanout_arbiter.sv
// Playfield scanout arbiter for the HDMI Tetris design.
// Tracks the encoder's pixel position and shares the single-port cell RAM
// between pixel scanout (inside the playfield band) and the game-logic
// writer (everywhere else). It also produces the RGB stream and a
// once-per-frame tick.
module playfield_scanout_arbiter #(
  parameter int PF_X0  = 240,
  parameter int PF_Y0  = 80,
  parameter int BORDER = 4
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        i_rd,
  input  logic        i_newline,
  input  logic        i_newframe,
  output logic [23:0] o_pixel,
  output logic [7:0]  o_ram_addr,
  output logic        o_ram_we,
  output logic [2:0]  o_ram_wdata,
  input  logic [2:0]  i_ram_rdata,
  input  logic        i_gw_req,
  output logic        o_gw_gnt,
  input  logic        i_gw_we,
  input  logic [7:0]  i_gw_addr,
  input  logic [2:0]  i_gw_data,
  output logic [2:0]  o_gw_rdata,
  output logic        o_frame_tick
);

  localparam logic [9:0] X_LO    = 10'(PF_X0);
  localparam logic [9:0] X_HI    = 10'(PF_X0 + 160);
  localparam logic [9:0] Y_LO    = 10'(PF_Y0);
  localparam logic [9:0] Y_HI    = 10'(PF_Y0 + 320);
  localparam logic [9:0] XB_LO   = 10'(PF_X0 - BORDER);
  localparam logic [9:0] XB_HI   = 10'(PF_X0 + 160 + BORDER);
  localparam logic [9:0] YB_LO   = 10'(PF_Y0 - BORDER);
  localparam logic [9:0] YB_HI   = 10'(PF_Y0 + 320 + BORDER);
  // One guard line before the band so the first playfield line already has
  // the RAM owned by scanout.
  localparam logic [9:0] Y_ENTER = 10'(PF_Y0 - 1);

  typedef enum logic {FREE = 1'b0, SCAN = 1'b1} state_t;

  state_t      state_q;
  logic        tick_q;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        gnt_q;

  logic [9:0]  dx, dy;
  logic        hit_p0, border_p0;
  logic [7:0]  scan_addr_p0;

  logic        vld_p1;
  logic        hit_p1, border_p1;
  logic [23:0] pixel_q;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [23:0] cell_color(input logic [2:0] c);
    logic [23:0] rgb;
    case (c)
      3'd0:    rgb = 24'h202020;
      3'd1:    rgb = 24'h00FFFF;
      3'd2:    rgb = 24'hFFFF00;
      3'd3:    rgb = 24'hA000F0;
      3'd4:    rgb = 24'h00FF00;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'hFFA500;
    endcase
    return rgb;
  endfunction

  // Next pixel position from the encoder strobes; newframe dominates newline.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_newframe) begin
      x_d = 10'd0;
      y_d = 10'd0;
    end else if (i_newline) begin
      x_d = {9'd0, i_rd};
      y_d = sat_inc(y_q);
    end else if (i_rd) begin
      x_d = sat_inc(x_q);
    end
  end

  // Position registers.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      x_q <= 10'd0;
      y_q <= 10'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Ownership FSM; the frame tick is registered alongside the state.
  always_ff @(posedge clk_25mhz) begin
    if (reset || i_newframe) begin
      state_q <= FREE;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (i_newline) begin
        case (state_q)
          FREE: if (y_d == Y_ENTER) state_q <= SCAN;
          SCAN: if (y_d == Y_HI) begin
            state_q <= FREE;
            tick_q  <= 1'b1;
          end
          default: state_q <= FREE;
        endcase
      end
    end
  end

  // ---- stage 0: region flags and cell address from the current position
  always_comb begin
    dx           = x_q - X_LO;
    dy           = y_q - Y_LO;
    scan_addr_p0 = 8'((dy >> 4) * 10 + (dx >> 4));
    hit_p0       = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
    border_p0    = !hit_p0 && (x_q >= XB_LO) && (x_q < XB_HI) &&
                   (y_q >= YB_LO) && (y_q < YB_HI);
  end

  // RAM port mux, steered only by the registered state.
  always_comb begin
    o_gw_gnt    = (state_q == FREE) && i_gw_req;
    o_ram_addr  = (state_q == SCAN) ? scan_addr_p0 : i_gw_addr;
    o_ram_we    = (state_q == FREE) && i_gw_req && i_gw_we;
    o_ram_wdata = (state_q == FREE) ? i_gw_data : 3'd0;
    o_gw_rdata  = i_ram_rdata & {3{gnt_q}};
  end

  // ---- stage 1: RAM data arrives; pixel valid and region flags follow it
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      gnt_q  <= 1'b0;
    end else begin
      vld_p1 <= i_rd;
      gnt_q  <= o_gw_gnt;
    end
  end

  // Region flags are pure data and need no reset.
  always_ff @(posedge clk_25mhz) begin
    hit_p1    <= hit_p0;
    border_p1 <= border_p0;
  end

  // ---- stage 2: registered RGB, held while no pixel is consumed
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      pixel_q <= 24'd0;
    end else if (vld_p1) begin
      if (hit_p1)         pixel_q <= cell_color(i_ram_rdata);
      else if (border_p1) pixel_q <= 24'hFFFFFF;
      else                pixel_q <= 24'h000000;
    end
  end

  assign o_pixel      = pixel_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_playfield_scanout_arbiter.sv
// Scoreboard bench for playfield_scanout_arbiter: randomized encoder and
// game-logic traffic, a reference model of position/ownership/colour, and
// a monitor that consumes expected values as the DUT presents them.
module tb_playfield_scanout_arbiter;

  localparam int PF_X0  = 240;
  localparam int PF_Y0  = 80;
  localparam int BORDER = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_rd = 1'b0, i_newline = 1'b0, i_newframe = 1'b0;
  logic [23:0] o_pixel;
  logic [7:0]  o_ram_addr;
  logic        o_ram_we;
  logic [2:0]  o_ram_wdata;
  logic [2:0]  ram_rdata;
  logic        i_gw_req = 1'b0, i_gw_we = 1'b0;
  logic [7:0]  i_gw_addr = 8'd0;
  logic [2:0]  i_gw_data = 3'd0;
  logic        o_gw_gnt;
  logic [2:0]  o_gw_rdata;
  logic        o_frame_tick;

  always #20 clk = ~clk;

  playfield_scanout_arbiter #(.PF_X0(PF_X0), .PF_Y0(PF_Y0), .BORDER(BORDER)) dut (
    .clk_25mhz(clk), .reset(reset), .i_rd(i_rd), .i_newline(i_newline),
    .i_newframe(i_newframe), .o_pixel(o_pixel), .o_ram_addr(o_ram_addr),
    .o_ram_we(o_ram_we), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata),
    .i_gw_req(i_gw_req), .o_gw_gnt(o_gw_gnt), .i_gw_we(i_gw_we),
    .i_gw_addr(i_gw_addr), .i_gw_data(i_gw_data), .o_gw_rdata(o_gw_rdata),
    .o_frame_tick(o_frame_tick)
  );

  // Synchronous-read single-port cell RAM (read returns old data on write).
  logic [2:0] mem [0:255];
  logic       preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? 3'd1 : ((i == 199) ? 3'd5 : 3'd0);
      ram_rdata <= 3'd0;
    end else begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      ram_rdata <= mem[o_ram_addr];
    end
  end

  // Reference model state.
  int         mx, my;
  bit         mscan;
  logic [2:0] ref_cells [0:199];

  typedef struct {bit tick; bit gchk; logic [2:0] gval;} cyc_t;
  logic [23:0] pq[$];
  cyc_t        cq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] lut(input int c);
    case (c)
      0: return 24'h202020;
      1: return 24'h00FFFF;
      2: return 24'hFFFF00;
      3: return 24'hA000F0;
      4: return 24'h00FF00;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'hFFA500;
    endcase
  endfunction

  function automatic logic [23:0] exp_pixel(input int x, input int y);
    if (x >= PF_X0 && x < PF_X0 + 160 && y >= PF_Y0 && y < PF_Y0 + 320)
      return lut(int'(ref_cells[((y - PF_Y0) / 16) * 10 + (x - PF_X0) / 16]));
    if (x >= PF_X0 - BORDER && x < PF_X0 + 160 + BORDER &&
        y >= PF_Y0 - BORDER && y < PF_Y0 + 320 + BORDER)
      return 24'hFFFFFF;
    return 24'h000000;
  endfunction

  function automatic bit full_line(input int ln);
    return ln == 0 || ln == 76 || ln == 77 || ln == 79 || ln == 80 || ln == 81 ||
           ln == 100 || ln == 128 || ln == 399 || ln == 400 || ln == 403 || ln == 404;
  endfunction

  // One stimulus cycle: drive, check combinational arbitration, push
  // expectations, advance the model.
  task automatic cycle(input bit rd, input bit nl, input bit nf, input bit gdir,
                       input bit greq, input bit gwe, input int gaddr, input int gdata);
    int   a;
    bit   gexp;
    cyc_t ent;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    i_rd = rd; i_newline = nl; i_newframe = nf;
    if (gdir) begin
      i_gw_req = greq; i_gw_we = gwe; i_gw_addr = 8'(gaddr); i_gw_data = 3'(gdata);
    end else begin
      a = int'($urandom_range(1, 197));
      if (a >= 37) a++;
      i_gw_req  = 1'($urandom_range(0, 1));
      i_gw_we   = 1'($urandom_range(0, 1));
      i_gw_addr = 8'(a);
      i_gw_data = 3'($urandom_range(0, 7));
    end
    #2;
    gexp = !mscan && i_gw_req;
    check("gw_gnt", 32'(o_gw_gnt), 32'(gexp));
    check("ram_we", 32'(o_ram_we), 32'(gexp && i_gw_we));
    if (!mscan) check("ram_addr_free", 32'(o_ram_addr), 32'(i_gw_addr));
    if (rd) pq.push_back(exp_pixel(mx, my));
    ent.gchk = gexp;
    ent.gval = gexp ? ref_cells[i_gw_addr] : 3'd0;
    if (gexp && i_gw_we) ref_cells[i_gw_addr] = i_gw_data;
    ent.tick = 1'b0;
    if (nf) begin
      mx = 0; my = 0; mscan = 1'b0;
    end else if (nl) begin
      mx = 0;
      if (my < 1023) my++;
      if (!mscan && my == PF_Y0 - 1) mscan = 1'b1;
      else if (mscan && my == PF_Y0 + 320) begin
        mscan = 1'b0;
        ent.tick = 1'b1;
      end
    end else if (rd && mx < 1023) begin
      mx++;
    end
    cq.push_back(ent);
  endtask

  task automatic rcycle(input bit rd, input bit nl);
    cycle(rd, nl, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset(input bit req);
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
    i_gw_req = req; i_gw_we = 1'b0; i_gw_addr = 8'd0; i_gw_data = 3'd0;
    @(negedge clk);
    #2;
    check("rst_pixel", 32'(o_pixel), 32'h0);
    check("rst_tick", 32'(o_frame_tick), 32'h0);
    check("rst_ram_we", 32'(o_ram_we), 32'h0);
    check("rst_ram_addr", 32'(o_ram_addr), 32'h0);
    check("rst_ram_wdata", 32'(o_ram_wdata), 32'h0);
    check("rst_gw_rdata", 32'(o_gw_rdata), 32'h0);
    check("rst_gw_gnt", 32'(o_gw_gnt), 32'(req));
    i_gw_req = 1'b1;
    #1;
    check("rst_gw_gnt_follows_req", 32'(o_gw_gnt), 32'h1);
    i_gw_req = 1'b0;
    pq.delete();
    cq.delete();
    mx = 0; my = 0; mscan = 1'b0;
  endtask

  task automatic read_line(input int nrd);
    for (int i = 0; i < nrd; i++) begin
      if ($urandom_range(0, 7) == 0) rcycle(1'b0, 1'b0);
      rcycle(1'b1, 1'b0);
    end
  endtask

  task automatic run_frame(input int abort_y, input int reset_y, input bit dirw);
    int nrd;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int ln = 0; ln < 480; ln++) begin
      if (ln > 0) rcycle(1'b0, 1'b1);
      if (ln == abort_y) begin
        read_line(300);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10, 0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10, 0);
        repeat (PF_Y0) rcycle(1'b0, 1'b1);
        read_line(20);
        return;
      end
      if (ln == reset_y) begin
        read_line(300);
        do_reset(1'b1);
        return;
      end
      if (dirw && ln == 5) begin
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 37, 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 37, 0);
      end
      nrd = full_line(ln) ? 410 : int'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) nrd = 410;
      read_line(nrd);
    end
  endtask

  // Monitor: consumes expectations as the registered outputs update.
  initial begin
    bit          pend;
    logic [23:0] last, e;
    cyc_t        c;
    pend = 1'b0;
    last = 24'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        pend = 1'b0;
        last = 24'd0;
      end else begin
        if (pend) begin
          if (pq.size() == 0) begin
            check("pixel_expected_present", 32'h0, 32'h1);
          end else begin
            e = pq.pop_front();
            check("pixel", 32'(o_pixel), 32'(e));
            last = e;
          end
        end else begin
          check("pixel_hold", 32'(o_pixel), 32'(last));
        end
        pend = i_rd;
        if (cq.size() == 0) begin
          check("cycle_expected_present", 32'h0, 32'h1);
        end else begin
          c = cq.pop_front();
          check("frame_tick", 32'(o_frame_tick), 32'(c.tick));
          if (c.gchk) check("gw_rdata", 32'(o_gw_rdata), 32'(c.gval));
        end
      end
    end
  end

  initial begin
    #8000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 200; i++) ref_cells[i] = 3'd0;
    ref_cells[0]   = 3'd1;
    ref_cells[199] = 3'd5;
    mx = 0; my = 0; mscan = 1'b0;
    @(posedge clk);
    #1 preload = 1'b0;
    do_reset(1'b0);
    run_frame(-1, -1, 1'b1);
    run_frame(-1, -1, 1'b0);
    run_frame(200, -1, 1'b0);
    run_frame(-1, 150, 1'b0);
    run_frame(-1, -1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    check("pixel_queue_drained", 32'(pq.size()), 32'h0);
    check("cycle_queue_drained", 32'(cq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
